// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding,
// byte-enable width and the response payload.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } dmem_resp_t;

endpackage

// File: rtl/dmem_ram_1rw.sv
// Single-port synchronous data RAM, DEPTH_WORDS x 32, byte-lane writes
// and registered read data. Contents are never reset.
// Ports:
//   clk   : clock
//   re    : read strobe; rdata updates on the following edge
//   we    : per-byte write enables, bit k gates bits [8k+7:8k]
//   idx   : word index
//   wdata : lane-positioned write data
//   rdata : registered read word
module dmem_ram_1rw
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [BE_W-1:0]   we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Byte-lane write and registered read share the single port.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BE_W); b++) begin
      if (we[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store path. Accepts one
// word-aligned request at a time, commits byte-lane writes at the accept
// edge, and returns a full read word (or an error for out-of-range words)
// over a valid/ready response channel.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_req_valid/o_req_ready: request handshake
//   i_req_write            : 1 = write, 0 = read
//   i_req_addr             : byte address, bits [1:0] ignored
//   i_req_wdata, i_req_be  : lane-positioned store data and byte enables
//   o_resp_valid/i_resp_ready : response handshake
//   o_resp_rdata, o_resp_err  : read word (0 for writes/errors), range error
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned N           = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [N-1:0]      i_req_wdata,
  input  logic [BE_W-1:0]   i_req_be,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [N-1:0]      o_resp_rdata,
  output logic              o_resp_err
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned WORD_W = ADDR_W - 2;

  dmem_state_e       state;
  dmem_state_e       state_next;
  dmem_resp_t        resp_q;
  logic [WORD_W-1:0] word_idx;
  logic              in_range;
  logic              accept;
  logic [BE_W-1:0]   ram_we;
  logic              ram_re;
  logic [N-1:0]      ram_rdata;
  logic              unused_addr_lsbs;

  assign word_idx         = i_req_addr[ADDR_W-1:2];
  assign unused_addr_lsbs = ^i_req_addr[1:0];

  // In range when every word-index bit above the RAM index is clear.
  assign in_range = (word_idx[WORD_W-1:IDX_W] == '0);
  assign accept   = (state == ST_IDLE) && i_req_valid;

  // Out-of-range requests never touch the RAM.
  assign ram_we = (accept && i_req_write && in_range) ? i_req_be : '0;
  assign ram_re = accept && !i_req_write && in_range;

  dmem_ram_1rw #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (i_clk),
    .re    (ram_re),
    .we    (ram_we),
    .idx   (word_idx[IDX_W-1:0]),
    .wdata (i_req_wdata),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = i_req_write ? ST_RESP : ST_READ;
        end
      end
      ST_READ: state_next = ST_RESP;
      ST_RESP: begin
        if (i_resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Response register: error captured at accept, read word loaded in READ.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      resp_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            resp_q.rdata <= '0;
            resp_q.err   <= !in_range;
          end
        end
        ST_READ: begin
          if (!resp_q.err) begin
            resp_q.rdata <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready  = (state == ST_IDLE);
  assign o_resp_valid = (state == ST_RESP);
  assign o_resp_rdata = resp_q.rdata;
  assign o_resp_err   = resp_q.err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expected
// responses, a negedge monitor pops and compares on each response handshake.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int fails  = 0;
  dmem_resp_t exp_q[$];
  dmem_resp_t mon_e;

  always #5 clk = ~clk;

  data_mem_responder #(
    .N           (32),
    .DEPTH_WORDS (1024),
    .ADDR_W      (32)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_be     (req_be),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_resp: got rdata=0x%08h err=%0b expected no response", resp_rdata, resp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, mon_e.rdata);
        check("resp_err", 32'(resp_err), 32'(mon_e.err));
      end
    end
  end

  // Issue one request, check latency, optional backpressure, return to idle.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata,
                        input logic exp_err, input int stall);
    bit got;
    int lat;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    if (stall > 0) resp_ready = 1'b0;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 20 cycles");
      void'(exp_q.pop_back());
      resp_ready = 1'b1;
      return;
    end
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    check("resp_latency", 32'(lat), wr ? 32'd1 : 32'd2);
    if (!got) begin
      resp_ready = 1'b1;
      return;
    end
    if (stall > 0) begin
      for (int k = 0; k < stall; k++) begin
        check("bp_valid", 32'(resp_valid), 32'd1);
        check("bp_req_ready", 32'(req_ready), 32'd0);
        check("bp_rdata", resp_rdata, exp_rdata);
        check("bp_err", 32'(resp_err), 32'(exp_err));
        if (k < stall - 1) @(negedge clk);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("idle_resp_valid", 32'(resp_valid), 32'd0);
    check("idle_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;

    // Byte-lane writes and merge readback.
    do_req(1'b1, 32'h0000_0000, 32'h0123_4567, 4'b1111, 32'h0, 1'b0, 0);
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, 0);
    do_req(1'b1, 32'h0000_0012, 32'h00AB_0000, 4'b0100, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAB_BEEF, 1'b0, 0);
    // Backpressure: five stalled cycles, handshake on the sixth.
    do_req(1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'hDEAB_BEEF, 1'b0, 5);
    // Out of range: first word past the end, write and read both flag err.
    do_req(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b1, 0);
    do_req(1'b0, 32'h0000_1000, 32'h0,         4'b1111, 32'h0, 1'b1, 0);
    do_req(1'b0, 32'h0000_0000, 32'h0,         4'b1111, 32'h0123_4567, 1'b0, 0);
    // Empty byte enables leave memory untouched.
    do_req(1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0, 1'b0, 0);
    do_req(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h0000_0020, 32'h0,         4'b1111, 32'h1122_3344, 1'b0, 0);
    // Last in-range word.
    do_req(1'b1, 32'h0000_0FFC, 32'hA5A5_5A5A, 4'b1111, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h0000_0FFC, 32'h0,         4'b0000, 32'hA5A5_5A5A, 1'b0, 0);
    // Address bits [1:0] ignored; top-lane write with stall on the write response.
    do_req(1'b1, 32'h0000_0013, 32'h7700_0000, 4'b1000, 32'h0, 1'b0, 2);
    do_req(1'b0, 32'h0000_0011, 32'h0,         4'b1111, 32'h77AB_BEEF, 1'b0, 0);

    // Reset while in READ: the read is dropped without a response.
    req_write = 1'b0;
    req_addr  = 32'h0000_0010;
    req_be    = 4'b1111;
    req_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    check("midrst_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(resp_valid), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("postrst_no_valid", 32'(resp_valid), 32'd0);
      check("postrst_req_ready", 32'(req_ready), 32'd1);
    end
    @(posedge clk); #1;
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'b1111, 32'h1122_3344, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's load/store path. It accepts word-aligned requests carrying pre-shifted store data and a 4-bit byte enable, commits byte-lane writes, and returns full 32-bit read words for the core to extract and extend. It sits between the MEM stage and the on-chip data RAM, behind a valid/ready request channel and a valid/ready response channel.

## Interface
- `N`, 32: data width; only 32 is supported.
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; must be a power of two.
- `ADDR_W`, 32: byte-address width.
- `i_clk` input 1: clock.
- `i_rst` input 1: reset; synchronous to `i_clk`, active-high.
- `i_req_valid` input 1: request present.
- `o_req_ready` output 1: responder can accept a request.
- `i_req_write` input 1: 1 = write, 0 = read.
- `i_req_addr` input ADDR_W: byte address; bits [1:0] are ignored.
- `i_req_wdata` input N: lane-positioned store data.
- `i_req_be` input 4: byte enables; bit k gates byte k, bits [8k+7:8k].
- `o_resp_valid` output 1: response present.
- `i_resp_ready` input 1: core accepts the response.
- `o_resp_rdata` output N: read word; 0 for writes and errors.
- `o_resp_err` output 1: address out of range.

## Operation
- **Word index:** `i_req_addr[ADDR_W-1:2]`.
- **Out of range:** the word index is >= `DEPTH_WORDS`. For writes, nothing is written. For reads, `o_resp_rdata` = 0. In both cases `o_resp_err` = 1.
- **Transfer rule:** a request is accepted on a cycle where `i_req_valid & o_req_ready` are both high. A response completes on a cycle where `o_resp_valid & i_resp_ready` are both high.
- **FSM states:** IDLE, READ, RESP.
  - **IDLE:** `o_req_ready` = 1. An accepted write (in range) commits the enabled bytes at the accept edge, then goes to RESP. An accepted read goes to READ. With no request, stay in IDLE.
  - **READ:** the RAM word is registered into the response register, then go to RESP. `o_req_ready` = 0.
  - **RESP:** `o_resp_valid` = 1, and `o_resp_rdata` and `o_resp_err` are held stable. When `i_resp_ready` = 1, go to IDLE. `o_req_ready` = 0, so there is one outstanding request at most.
- **Writes with `i_req_be` = 0000:** no RAM change, normal response (`o_resp_err` = 0).
- **Read `i_req_be`:** ignored; the full word is always returned.
- **Unknown read data:** uninitialised RAM contents are don't-care. The bench must write a location before reading it.
- **Reset:**
  - State goes to IDLE.
  - `o_req_ready` = 1, `o_resp_valid` = 0, `o_resp_rdata` = 0, `o_resp_err` = 0.
  - RAM contents are not cleared.
- **Reset mid-operation:** a pending READ or RESP is dropped and no response is issued. A write already committed stays committed.

## Timing
- **Write accepted at edge T:** the RAM is updated at T. `o_resp_valid` is high from T+1.
- **Read accepted at edge T:** RAM read at T+1. `o_resp_valid` is high from T+2.
- **Throughput:** at best, one write every 2 cycles and one read every 3 cycles, with `i_resp_ready` tied high.
- **Back-to-back transfers:** the response handshake at edge T returns the FSM to IDLE. The next request can be accepted at T+1, but not in the same cycle as the response handshake.
- **Backpressure:** `o_resp_*` are held unchanged while `i_resp_ready` = 0, for any number of cycles.
- **Read-after-write:** a read issued after a write's response reads the new data, because the write completes before its response.
- **Registered outputs:** all outputs are registered or decoded from the state only. There is no combinational path from inputs to outputs.

## Structure
- **Package `dmem_pkg`:**
  - state enum `dmem_state_e` (IDLE, READ, RESP);
  - localparam `BE_W` = 4;
  - response struct `{rdata, err}`.
- **Sub-module `dmem_ram_1rw`:**
  - single-port synchronous RAM, `DEPTH_WORDS` x 32;
  - per-byte write enables;
  - registered read data.
- **Top level:** FSM, range check, and response register.

## Test plan
- **Reset values:** assert `i_rst` for 2 cycles, then release. Expect `o_req_ready` = 1, `o_resp_valid` = 0, rdata = 0, err = 0.
- **Byte-lane write:**
  - Write `addr` 0x10, data 0xDEADBEEF, `be` 1111; expect the response at T+1.
  - Write `addr` 0x12, data 0x00AB0000, `be` 0100.
  - Read `addr` 0x10: expect 0xDEABBEEF at T+2, err = 0.
- **Backpressure:** read with `i_resp_ready` = 0 for 5 cycles. Response stays valid and stable, `o_req_ready` stays 0, and the handshake on cycle 6 returns to IDLE.
- **Out of range:** with `DEPTH_WORDS` = 1024, write to 0x1000 with `be` 1111, then read 0x1000. Both responses give err = 1 and rdata = 0. A read of 0x0 is unchanged.
- **Empty enables:** write `be` 0000 to 0x20 holding 0x11223344. Response err = 0, and a readback returns 0x11223344.
- **Reset mid-read:** accept a read, assert `i_rst` in the READ state. No `o_resp_valid` pulse occurs, and the next request after release is accepted normally.
